// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for the single-slot I/O register port (IDLE -> ACCESS -> RESP).
// Define IO_ARB_FIXPRI_EN for m0-priority arbitration with m1 anti-starvation; default is round-robin.
module io_bus_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] io_addr,
  output logic              io_we,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state_reg;
  logic   owner_reg;   // 0 = m0, 1 = m1
  logic   grant_m1;

`ifdef IO_ARB_FIXPRI_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  logic [CNT_W-1:0] starve_cnt_reg;

  always_comb begin
    if (m0_req && m1_req) grant_m1 = (starve_cnt_reg == STARVE_LIM);
    else                  grant_m1 = m1_req;
  end
`else
  logic rr_last_reg;   // last granted master, 1 = m1

  always_comb begin
    if (m0_req && m1_req) grant_m1 = ~rr_last_reg;
    else                  grant_m1 = m1_req;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      owner_reg <= 1'b0;
`ifdef IO_ARB_FIXPRI_EN
      starve_cnt_reg <= '0;
`else
      rr_last_reg <= 1'b1;
`endif
      io_addr  <= '0;
      io_wdata <= '0;
      io_we    <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
      m0_ack   <= 1'b0;
      m1_ack   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner_reg <= grant_m1;
            io_we     <= grant_m1 ? m1_we    : m0_we;
            io_addr   <= grant_m1 ? m1_addr  : m0_addr;
            io_wdata  <= grant_m1 ? m1_wdata : m0_wdata;
            state_reg <= ACCESS;
`ifdef IO_ARB_FIXPRI_EN
            // Only m0 grants made while m1 waits count; saturates at the limit.
            if (grant_m1)
              starve_cnt_reg <= '0;
            else if (m1_req && starve_cnt_reg != STARVE_LIM)
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
`else
            rr_last_reg <= grant_m1;
`endif
          end
        end
        ACCESS: begin
          // Captured for writes too: the value seen is the pre-write contents.
          io_we <= 1'b0;
          if (owner_reg) begin
            m1_rdata <= io_rdata;
            m1_ack   <= 1'b1;
          end else begin
            m0_rdata <= io_rdata;
            m0_ack   <= 1'b1;
          end
          state_reg <= RESP;
        end
        RESP: begin
          m0_ack    <= 1'b0;
          m1_ack    <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: vector table of single-master accesses plus
// contention, protocol-violation and mid-access reset sequences.
module tb_io_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_ack, m1_ack, io_we;
  logic [7:0] m0_rdata, m1_rdata, io_addr, io_wdata, io_rdata;

  logic [7:0] mem [256];
  logic       mem_clr;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic       master;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  io_bus_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .io_addr(io_addr), .io_we(io_we), .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  always #5 clock = ~clock;

  // I/O register file model: combinational read, write on posedge
  assign io_rdata = mem[io_addr];
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h80] <= 8'h5a;
    end else if (io_we) begin
      mem[io_addr] <= io_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input vec_t v);
    if (v.master) begin
      m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
    end else begin
      m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
    end
  endtask

  initial begin
    logic [7:0] m0_prev, m1_prev;
    int got, cyc, last_cyc;
    logic exp_m1;

    reset_n = 1'b0; mem_clr = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;

    //        master we  addr   wdata  exp_rdata
    vecs[0] = '{1'b0, 1'b1, 8'h3c, 8'ha5, 8'h00};  // write returns pre-write value
    vecs[1] = '{1'b0, 1'b0, 8'h3c, 8'h00, 8'ha5};
    vecs[2] = '{1'b1, 1'b0, 8'h80, 8'h00, 8'h5a};
    vecs[3] = '{1'b1, 1'b1, 8'h80, 8'hc3, 8'h5a};
    vecs[4] = '{1'b0, 1'b0, 8'h80, 8'h00, 8'hc3};
    vecs[5] = '{1'b0, 1'b1, 8'h3c, 8'h11, 8'ha5};

    repeat (2) @(posedge clock);
    #1;
    chk("reset io_we", io_we, 0);
    chk("reset m0_ack", m0_ack, 0);
    chk("reset m1_ack", m1_ack, 0);
    chk("reset io_addr", io_addr, 0);
    chk("reset io_wdata", io_wdata, 0);
    chk("reset m0_rdata", m0_rdata, 0);
    chk("reset m1_rdata", m1_rdata, 0);
    reset_n = 1'b1; mem_clr = 1'b0;
    m0_prev = 8'h00; m1_prev = 8'h00;

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i]);
      @(posedge clock); #1;  // ACCESS
      chk($sformatf("v%0d io_we", i), io_we, vecs[i].we);
      chk($sformatf("v%0d io_addr", i), io_addr, vecs[i].addr);
      chk($sformatf("v%0d io_wdata", i), io_wdata, vecs[i].wdata);
      chk($sformatf("v%0d early ack", i), {m1_ack, m0_ack}, 0);
      @(posedge clock); #1;  // RESP
      chk($sformatf("v%0d io_we off", i), io_we, 0);
      if (vecs[i].master) begin
        chk($sformatf("v%0d m1_ack", i), m1_ack, 1);
        chk($sformatf("v%0d m0_ack", i), m0_ack, 0);
        chk($sformatf("v%0d m1_rdata", i), m1_rdata, vecs[i].exp_rdata);
        chk($sformatf("v%0d m0_rdata kept", i), m0_rdata, m0_prev);
        m1_prev = vecs[i].exp_rdata;
        m1_req = 1'b0;
      end else begin
        chk($sformatf("v%0d m0_ack", i), m0_ack, 1);
        chk($sformatf("v%0d m1_ack", i), m1_ack, 0);
        chk($sformatf("v%0d m0_rdata", i), m0_rdata, vecs[i].exp_rdata);
        chk($sformatf("v%0d m1_rdata kept", i), m1_rdata, m1_prev);
        m0_prev = vecs[i].exp_rdata;
        m0_req = 1'b0;
      end
      $display("vec %0d: m%0d we=%0d addr=%h wdata=%h rdata=%h", i, vecs[i].master,
               vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
      @(posedge clock); #1;  // back in IDLE
      chk($sformatf("v%0d idle acks", i), {m1_ack, m0_ack}, 0);
    end

    // Request dropped during ACCESS still completes with an ack
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h3c;
    @(posedge clock); #1;
    m0_req = 1'b0;
    @(posedge clock); #1;
    chk("drop m0_ack", m0_ack, 1);
    chk("drop m0_rdata", m0_rdata, 8'h11);
    $display("drop: m0 read 3c rdata=%h ack=%0d", m0_rdata, m0_ack);
    @(posedge clock); #1;

    // Both masters held: m1 first (last grant was m0), one ack every 3 cycles
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h3c;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h80;
    got = 0; cyc = 0; last_cyc = 0;
    while (got < 10 && cyc < 40) begin
      @(posedge clock); #1;
      cyc++;
      if (m0_ack || m1_ack) begin
`ifdef IO_ARB_FIXPRI_EN
        exp_m1 = ((got % 5) == 4);
`else
        exp_m1 = ((got % 2) == 0);
`endif
        chk($sformatf("arb%0d m1_ack", got), m1_ack, exp_m1);
        chk($sformatf("arb%0d m0_ack", got), m0_ack, !exp_m1);
        if (exp_m1) chk($sformatf("arb%0d m1_rdata", got), m1_rdata, 8'hc3);
        else        chk($sformatf("arb%0d m0_rdata", got), m0_rdata, 8'h11);
        chk($sformatf("arb%0d spacing", got), cyc - last_cyc, (got == 0) ? 2 : 3);
        $display("arb %0d: cycle %0d m0_ack=%0d m1_ack=%0d", got, cyc, m0_ack, m1_ack);
        last_cyc = cyc;
        got++;
        if (got == 10) begin
          m0_req = 1'b0; m1_req = 1'b0;
        end
      end
    end
    chk("arb grants seen", got, 10);
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clock); #1;

    // Reset during an m1 read ACCESS: no ack, then the held request is re-served
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h80;
    @(posedge clock); #1;
    chk("rst access io_addr", io_addr, 8'h80);
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk("rst m1_ack", m1_ack, 0);
    chk("rst io_we", io_we, 0);
    chk("rst io_addr", io_addr, 0);
    reset_n = 1'b1;
    cyc = 0;
    while (!m1_ack && cyc < 6) begin
      @(posedge clock); #1;
      cyc++;
    end
    chk("rst reserve latency", cyc, 2);
    chk("rst reserve m1_rdata", m1_rdata, 8'hc3);
    $display("reset mid-access: m1 re-served after %0d cycles rdata=%h", cyc, m1_rdata);
    m1_req = 1'b0;
    @(posedge clock); #1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
